// File: rtl/cpu_packet_assembler.sv
// rtl/cpu_packet_assembler.sv - store-and-forward packet assembler between the NoC output and the CPU side
module cpu_packet_assembler #(
    parameter int FLIT_WIDTH = 64,
    parameter int MAX_FLITS  = 8,
    parameter int LEN_W      = $clog2(MAX_FLITS + 1)
) (
    input  logic                  nocclk,
    input  logic                  rst_n,
    input  logic                  in_flit_valid,
    output logic                  in_flit_ready,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic                  out_flit_valid,
    input  logic                  out_flit_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_flit_last,
    output logic [LEN_W-1:0]      out_packet_len,
    output logic [7:0]            err_count,
    output logic                  err_pulse
);

    localparam int PTR_W = $clog2(MAX_FLITS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_FLITS);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    logic [1:0]            state, nxt_state;
    logic [LEN_W-1:0]      count, nxt_count;
    logic [PTR_W-1:0]      rd_ptr, nxt_rd_ptr;
    logic [FLIT_WIDTH-1:0] pkt_buf [MAX_FLITS];

    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic                  err;
    logic [1:0]            ftype;
    logic                  accept;
    logic                  deliver;
    logic                  is_full;
    logic                  at_last;

    assign ftype   = in_flit[FLIT_WIDTH-1:FLIT_WIDTH-2];
    assign is_full = (count == CNT_MAX);
    assign at_last = (LEN_W'(rd_ptr) == (count - CNT_ONE));

    // All CPU-side outputs are decoded from registered state only, so they
    // stay stable for as long as the consumer back-pressures.
    assign in_flit_ready  = (state != S_DELIVER);
    assign out_flit_valid = (state == S_DELIVER);
    assign out_flit_last  = out_flit_valid && at_last;
    assign out_packet_len = out_flit_valid ? count : '0;
    assign out_flit       = out_flit_valid ? pkt_buf[rd_ptr] : '0;

    assign accept  = in_flit_valid && in_flit_ready;
    assign deliver = out_flit_valid && out_flit_ready;

    always_comb begin
        nxt_state  = state;
        nxt_count  = count;
        nxt_rd_ptr = rd_ptr;
        wr_en      = 1'b0;
        wr_idx     = '0;
        err        = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (ftype)
                        FT_HEAD: begin
                            wr_en     = 1'b1;
                            nxt_count = CNT_ONE;
                            nxt_state = S_COLLECT;
                        end
                        FT_HT: begin
                            wr_en     = 1'b1;
                            nxt_count = CNT_ONE;
                            nxt_state = S_DELIVER;
                        end
                        default: err = 1'b1;
                    endcase
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    case (ftype)
                        FT_BODY: begin
                            if (is_full) begin
                                err       = 1'b1;
                                nxt_state = S_DROP;
                            end else begin
                                wr_en     = 1'b1;
                                wr_idx    = count[PTR_W-1:0];
                                nxt_count = count + CNT_ONE;
                            end
                        end
                        FT_TAIL: begin
                            if (is_full) begin
                                err       = 1'b1;
                                nxt_count = '0;
                                nxt_state = S_IDLE;
                            end else begin
                                wr_en     = 1'b1;
                                wr_idx    = count[PTR_W-1:0];
                                nxt_count = count + CNT_ONE;
                                nxt_state = S_DELIVER;
                            end
                        end
                        FT_HEAD: begin
                            // New head aborts the partial packet and restarts collection.
                            err       = 1'b1;
                            wr_en     = 1'b1;
                            nxt_count = CNT_ONE;
                        end
                        default: begin
                            err       = 1'b1;
                            wr_en     = 1'b1;
                            nxt_count = CNT_ONE;
                            nxt_state = S_DELIVER;
                        end
                    endcase
                end
            end

            S_DROP: begin
                // The overflow was already counted; the rest of the packet is
                // swallowed silently until a framing boundary.
                if (accept) begin
                    case (ftype)
                        FT_HEAD: begin
                            wr_en     = 1'b1;
                            nxt_count = CNT_ONE;
                            nxt_state = S_COLLECT;
                        end
                        FT_BODY: ;
                        default: begin
                            nxt_count = '0;
                            nxt_state = S_IDLE;
                        end
                    endcase
                end
            end

            default: begin
                if (deliver) begin
                    if (at_last) begin
                        nxt_rd_ptr = '0;
                        nxt_count  = '0;
                        nxt_state  = S_IDLE;
                    end else begin
                        nxt_rd_ptr = rd_ptr + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge nocclk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= nxt_state;
            count     <= nxt_count;
            rd_ptr    <= nxt_rd_ptr;
            err_pulse <= err;
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Buffer needs no reset: nothing is read before it has been written.
    always_ff @(posedge nocclk) begin
        if (wr_en) begin
            pkt_buf[wr_idx] <= in_flit;
        end
    end

endmodule
